// File: rtl/loader_pkg.sv
// Shared widths, length limit and state encoding for the sample loader.
package loader_pkg;

    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_DATA_W = 14;
    localparam int unsigned DEF_CNT_W  = 12;

    // Two banks of 1024 words each hold at most 2048 samples.
    localparam int unsigned MAX_LEN = 2048;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StFlush = 2'd2
    } loader_state_e;

endpackage

// File: rtl/loader_fsm.sv
// Load sequencer: state register, sample index counter and end-of-load compare.
module loader_fsm
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  length_i,
    input  logic [CNT_W-1:0]  len_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              len_err_o,
    output logic              load_start_o,
    output logic              xfer_o,
    output logic [ADDR_W-1:0] pair_o,
    output logic              odd_o
);

    localparam logic [CNT_W-1:0] MaxLen = CNT_W'(MAX_LEN);

    loader_state_e    state_q;
    logic [CNT_W-1:0] idx_q;
    logic             s_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             len_err_q;
    logic             last;

    // Decode accepted start, transfer and final-sample conditions.
    always_comb begin
        load_start_o = (state_q == StIdle) && start_i && (length_i != '0) && (length_i <= MaxLen);
        xfer_o       = s_valid_i && s_ready_q;
        last         = (idx_q == (len_i - CNT_W'(1)));
    end

    // State, index and registered status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        if (length_i == '0) begin
                            done_q <= 1'b1;
                        end else if (length_i > MaxLen) begin
                            len_err_q <= 1'b1;
                        end else begin
                            idx_q     <= '0;
                            state_q   <= StLoad;
                            s_ready_q <= 1'b1;
                            busy_q    <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    if (xfer_o) begin
                        idx_q <= idx_q + CNT_W'(1);
                        if (last) begin
                            // Final write lands next cycle; done rides with it.
                            state_q   <= StFlush;
                            s_ready_q <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end
                end
                StFlush: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= StIdle;
                    s_ready_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready_o = s_ready_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign len_err_o = len_err_q;
    assign pair_o    = idx_q[ADDR_W:1];
    assign odd_o     = idx_q[0];

endmodule

// File: rtl/sample_loader.sv
// Streams samples into two banks: even indices to bank 1, odd indices to bank 2.
module sample_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  length,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              we1,
    output logic              we2,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              len_err
);

    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  len_q;
    logic              load_start;
    logic              xfer;
    logic [ADDR_W-1:0] pair;
    logic              odd;
    logic              we1_q;
    logic              we2_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    loader_fsm #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_fsm (
        .clk_i        (iclk),
        .rst_i        (irst),
        .start_i      (start),
        .length_i     (length),
        .len_i        (len_q),
        .s_valid_i    (s_valid),
        .s_ready_o    (s_ready),
        .busy_o       (busy),
        .done_o       (done),
        .len_err_o    (len_err),
        .load_start_o (load_start),
        .xfer_o       (xfer),
        .pair_o       (pair),
        .odd_o        (odd)
    );

    // Command latches, captured only when the sequencer accepts a start.
    always_ff @(posedge iclk) begin
        if (irst) begin
            base_q <= '0;
            len_q  <= '0;
        end else if (load_start) begin
            base_q <= base_addr;
            len_q  <= length;
        end
    end

    // Write port: one-cycle strobe per transfer; address wraps within the bank.
    always_ff @(posedge iclk) begin
        if (irst) begin
            we1_q   <= 1'b0;
            we2_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we1_q <= xfer & ~odd;
            we2_q <= xfer & odd;
            if (xfer) begin
                waddr_q <= base_q + pair;
                wdata_q <= s_data;
            end
        end
    end

    assign we1   = we1_q;
    assign we2   = we2_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

endmodule

// File: tb/tb_sample_loader.sv
// Randomised scoreboard bench for sample_loader.
module tb_sample_loader;

    localparam int EV_DONE = 1;
    localparam int EV_LERR = 2;

    typedef struct {
        int bank;
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int kind;
        int with_wr;
    } evt_t;

    logic        iclk;
    logic        irst;
    logic        start;
    logic [9:0]  base_addr;
    logic [11:0] length;
    logic        s_valid;
    logic [13:0] s_data;
    logic        s_ready;
    logic        we1;
    logic        we2;
    logic [9:0]  waddr;
    logic [13:0] wdata;
    logic        busy;
    logic        done;
    logic        len_err;

    wr_t  exp_wr[$];
    evt_t exp_evt[$];
    int   total = 0;
    int   bad = 0;

    sample_loader dut (
        .iclk      (iclk),
        .irst      (irst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .we1       (we1),
        .we2       (we2),
        .waddr     (waddr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .len_err   (len_err)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge iclk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write or a status pulse.
    always @(negedge iclk) begin
        wr_t  w;
        evt_t e;
        if (we1 && we2) check("we_exclusive", 1, 0);
        if (we1 || we2) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                w = exp_wr.pop_front();
                check("wr_bank", we2 ? 2 : 1, w.bank);
                check("wr_addr", int'(waddr), w.addr);
                check("wr_data", int'(wdata), w.data);
            end
        end
        if (done) begin
            if (exp_evt.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_evt.pop_front();
                check("done_kind", EV_DONE, e.kind);
                check("done_with_write", int'(we1 | we2), e.with_wr);
            end
        end
        if (len_err) begin
            if (exp_evt.size() == 0) begin
                check("unexpected_len_err", 1, 0);
            end else begin
                e = exp_evt.pop_front();
                check("len_err_kind", EV_LERR, e.kind);
            end
        end
    end

    task automatic issue_start(input int b, input int l);
        base_addr = 10'(b);
        length    = 12'(l);
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    // mode 0: valid every cycle, 1: random valid, 2: 1,0,0,1,1 pattern.
    // intr_at >= 0 pulses a competing start on that cycle of the load.
    task automatic run_load(input int b, input int l, input int mode, input int intr_at);
        int pat[5] = '{1, 0, 0, 1, 1};
        int i = 0;
        int cyc = 0;
        bit v;
        issue_start(b, l);
        check("s_ready_in_load", int'(s_ready), 1);
        check("busy_in_load", int'(busy), 1);
        while (i < l) begin
            case (mode)
                0: v = 1'b1;
                1: v = ($urandom_range(0, 99) < 70);
                default: v = pat[cyc % 5] != 0;
            endcase
            if (cyc == intr_at) begin
                start     = 1'b1;
                base_addr = 10'(b ^ 'h155);
                length    = 12'd5;
            end else begin
                start = 1'b0;
            end
            s_valid = v;
            s_data  = 14'($urandom_range(0, 16383));
            if (v) begin
                exp_wr.push_back('{(i % 2) + 1, (b + i / 2) % 1024, int'(s_data)});
                if (i == l - 1) exp_evt.push_back('{EV_DONE, 1});
                i++;
            end
            step();
            cyc++;
        end
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = 14'($urandom_range(0, 16383));
        check("s_ready_in_flush", int'(s_ready), 0);
        check("busy_in_flush", int'(busy), 1);
        step();
        s_valid = 1'b0;
        check("busy_after_load", int'(busy), 0);
        check("s_ready_after_load", int'(s_ready), 0);
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        irst      = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        repeat (3) step();
        irst = 1'b0;
        check("rst_s_ready", int'(s_ready), 0);
        check("rst_we1", int'(we1), 0);
        check("rst_we2", int'(we2), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_len_err", int'(len_err), 0);
        check("rst_waddr", int'(waddr), 0);
        check("rst_wdata", int'(wdata), 0);
        step();

        // Basic load with fixed data 1..4.
        begin
            issue_start(0, 4);
            for (int k = 0; k < 4; k++) begin
                s_valid = 1'b1;
                s_data  = 14'(k + 1);
                exp_wr.push_back('{(k % 2) + 1, k / 2, k + 1});
                if (k == 3) exp_evt.push_back('{EV_DONE, 1});
                step();
            end
            s_valid = 1'b0;
            step();
            check("basic_busy_after", int'(busy), 0);
            step();
        end

        run_load(37, 3, 2, -1);
        run_load(1022, 6, 0, -1);
        run_load(1020, 10, 1, -1);

        // Length 0: immediate done, never busy.
        exp_evt.push_back('{EV_DONE, 0});
        issue_start(100, 0);
        check("len0_busy", int'(busy), 0);
        step();
        check("len0_busy_later", int'(busy), 0);

        // Length 2049: rejected.
        exp_evt.push_back('{EV_LERR, 0});
        issue_start(5, 2049);
        check("len2049_busy", int'(busy), 0);
        step();
        check("len2049_busy_later", int'(busy), 0);

        // Competing start mid-load must be ignored.
        run_load(200, 9, 1, 3);

        // Mid-load reset after 2 of 8 transfers.
        begin
            issue_start(300, 8);
            for (int k = 0; k < 2; k++) begin
                s_valid = 1'b1;
                s_data  = 14'($urandom_range(0, 16383));
                exp_wr.push_back('{(k % 2) + 1, 300 + k / 2, int'(s_data)});
                step();
            end
            irst    = 1'b1;
            s_data  = 14'($urandom_range(0, 16383));
            step();
            irst    = 1'b0;
            s_valid = 1'b0;
            check("mrst_s_ready", int'(s_ready), 0);
            check("mrst_we1", int'(we1), 0);
            check("mrst_we2", int'(we2), 0);
            check("mrst_busy", int'(busy), 0);
            check("mrst_done", int'(done), 0);
            check("mrst_waddr", int'(waddr), 0);
            check("mrst_wdata", int'(wdata), 0);
            repeat (3) step();
            run_load(301, 2, 0, -1);
        end

        for (int n = 0; n < 8; n++) begin
            run_load($urandom_range(0, 1023), $urandom_range(1, 40), 1,
                     ($urandom_range(0, 1) != 0) ? $urandom_range(0, 10) : -1);
        end

        run_load(512, 2048, 0, -1);

        repeat (4) step();
        check("writes_outstanding", exp_wr.size(), 0);
        check("events_outstanding", exp_evt.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sample_loader.md
Name: sample_loader

Overview:
- Write-side counterpart of the threshold-compare read path.
- Accepts a stream of 14-bit samples over a valid/ready handshake and writes them into the two sample memories. Even-indexed samples go to bank 1 and odd-indexed samples go to bank 2, so the pair layout matches the two-bank position split used by the readers.
- A start/length command frames each load; busy and done report progress to the control logic.

Parameters:
- ADDR_W, 10, address width of each memory bank (1024 words per bank).
- DATA_W, 14, sample width.
- CNT_W, 12, width of the length field (maximum 2048 samples = 2 x 1024).

Ports:
- iclk  input  1  clock; all logic on the rising edge.
- irst  input  1  synchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- base_addr  input  ADDR_W  first word address in both banks; latched on an accepted start.
- length  input  CNT_W  number of samples to load; latched on an accepted start.
- s_valid  input  1  sample available.
- s_data  input  DATA_W  sample value.
- s_ready  output  1  loader can accept a sample this cycle.
- we1  output  1  write enable, bank 1.
- we2  output  1  write enable, bank 2.
- waddr  output  ADDR_W  write address, shared by both banks.
- wdata  output  DATA_W  write data, shared by both banks.
- busy  output  1  high in LOAD and FLUSH.
- done  output  1  one-cycle pulse when a load completes.
- len_err  output  1  one-cycle pulse when a start is rejected because length > 2048.

Behaviour:
- Reset (synchronous, irst=1 at an edge):
  - State goes to IDLE.
  - s_ready, we1, we2, busy, done and len_err all go to 0.
  - waddr, wdata and the sample counter go to 0.
  - Reset mid-load abandons the load immediately; no further writes occur; done is not pulsed.
- States:
  - IDLE: s_ready=0, busy=0.
    - start=1 and length=0: done=1 next cycle, stay IDLE.
    - start=1 and length>2048: len_err=1 next cycle, stay IDLE.
    - start=1 otherwise: latch base_addr and length, clear idx, go to LOAD.
  - LOAD: s_ready=1, busy=1.
    - A transfer occurs when s_valid and s_ready are both 1.
    - Transfer at edge N: at N+1, wdata=s_data, waddr=(base+idx>>1) mod 2^ADDR_W, we1=~idx[0], we2=idx[0], all for exactly one cycle; idx increments.
    - Write latency is 1 cycle from the accepting edge.
    - No transfer (s_valid=0) means we1=we2=0 that cycle; the loader waits indefinitely.
    - A transfer with idx==length-1 moves the state to FLUSH.
  - FLUSH: s_ready=0, busy=1. The final write is on the bus this cycle and done=1 in the same cycle; next state is IDLE.
- Back-to-back transfers sustain one write per cycle.
- we1 and we2 are never both high.
- Address arithmetic is modulo 2^ADDR_W: base=1020 with length=10 writes addresses 1020..1023 and then 0 in both banks.
- For odd length, bank 2 receives one fewer word than bank 1.
- start is ignored outside IDLE, including the FLUSH cycle. A load is never restarted without going through IDLE.
- s_data is ignored when no transfer occurs. waddr and wdata hold their last values when we1=we2=0.

Decomposition:
- Shared package `loader_pkg`:
  - ADDR_W, DATA_W, CNT_W defaults.
  - MAX_LEN = 2048.
  - State encoding constants IDLE/LOAD/FLUSH.
- One sub-module, `loader_fsm`, holds the state register, idx counter and termination compare.
- The top-level loader holds the command latches, the address adder and the write-port output registers.

Test Plan:
- Basic load: base=0, length=4, s_valid held high with data 0x001..0x004 -> we1 at addr0=0x001, we2 at addr0=0x002, we1 at addr1=0x003, we2 at addr1=0x004 on consecutive cycles; done pulses with the last write; busy low afterwards.
- Backpressure gaps: length=3, s_valid toggled 1,0,0,1,1 -> exactly 3 writes, no we during the gaps, correct bank/address on each write.
- Wrap-around: base=1022, length=6 -> addresses 1022,1022,1023,1023,0,0 with alternating we1/we2.
- Edge lengths:
  - length=0 -> done 1 cycle after start, busy never set, no writes.
  - length=2049 -> len_err pulse, no writes.
  - length=2048 -> 1024 writes per bank.
- Mid-load reset: reset asserted after 2 of 8 transfers -> all outputs 0 next cycle, no done. A following start with length=2 completes normally.
- Start while busy: start pulsed during LOAD with a different base -> ignored; the original load finishes with the original addresses.
